// File: rtl/regfile_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard_pkg
//   Shared sizing constants for the integer register file and its pending-write
//   scoreboard.
//   DATA_WIDTH     : register data width
//   REG_ADDR_WIDTH : register index width
//   NUM_REGS       : number of architectural registers (2**REG_ADDR_WIDTH)
//   PEND_WIDTH     : width of the per-register in-flight write counter
//   X0_IDX         : index of the hardwired-zero register
// -----------------------------------------------------------------------------
package regfile_scoreboard_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int NUM_REGS       = 2 ** REG_ADDR_WIDTH;
    localparam int PEND_WIDTH     = 2;
    localparam int X0_IDX         = 0;

endpackage : regfile_scoreboard_pkg

// File: rtl/regfile_scoreboard_pend_counter.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard_pend_counter
//   Saturating up/down counter of issued-but-not-written-back writes for one
//   architectural register. Simultaneous inc and dec cancel out. The counter
//   never wraps in either direction.
//   clk     : clock
//   reset   : synchronous active-high clear
//   inc_i   : one more write issued to this register
//   dec_i   : one write to this register retired through writeback
//   count_o : current in-flight write count
// -----------------------------------------------------------------------------
module regfile_scoreboard_pend_counter #(
    parameter int PEND_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc_i,
    input  logic                  dec_i,
    output logic [PEND_WIDTH-1:0] count_o
);

    logic [PEND_WIDTH-1:0] count_q;
    logic [PEND_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i && (count_q != '1)) begin
            count_d = count_q + PEND_WIDTH'(1);
        end else if (dec_i && !inc_i && (count_q != '0)) begin
            count_d = count_q - PEND_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule : regfile_scoreboard_pend_counter

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//   Architectural integer register file with two combinational read ports
//   (write-to-read bypass from the writeback port) and a per-register
//   pending-write scoreboard used by decode for RAW hazard stalls.
//   clk, reset            : clock, synchronous active-high reset
//   wb_addr/wb_data/wb_en : writeback port (writes to x0 are dropped)
//   rs1_addr/rs1_data     : read port 1 (combinational)
//   rs2_addr/rs2_data     : read port 2 (combinational)
//   issue_valid/issue_rd/issue_wr : uop issued by decode and its destination
//   rs1_busy/rs2_busy     : source has a pending write not yet bypassable
//   issue_ready           : low when issue_rd's pending counter is saturated
// -----------------------------------------------------------------------------
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int DATA_WIDTH     = regfile_scoreboard_pkg::DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = regfile_scoreboard_pkg::REG_ADDR_WIDTH,
    parameter int NUM_REGS       = regfile_scoreboard_pkg::NUM_REGS,
    parameter int PEND_WIDTH     = regfile_scoreboard_pkg::PEND_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0]     wb_data,
    input  logic                      wb_en,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
    output logic [DATA_WIDTH-1:0]     rs1_data,
    output logic [DATA_WIDTH-1:0]     rs2_data,
    input  logic                      issue_valid,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
    input  logic                      issue_wr,
    output logic                      rs1_busy,
    output logic                      rs2_busy,
    output logic                      issue_ready
);

    localparam logic [REG_ADDR_WIDTH-1:0] X0_ADDR  = REG_ADDR_WIDTH'(X0_IDX);
    localparam logic [PEND_WIDTH-1:0]     PEND_ONE = PEND_WIDTH'(1);
    localparam logic [PEND_WIDTH-1:0]     PEND_MAX = '1;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [PEND_WIDTH-1:0] pend   [NUM_REGS];

    // Writeback and issue are ignored while reset is held, so the qualified
    // writeback also drives the bypass muxes.
    logic wb_fire;
    logic wb_nz;
    logic inc_fire;
    logic dec_fire;

    assign wb_fire = wb_en && !reset;
    assign wb_nz   = wb_fire && (wb_addr != X0_ADDR);

    // issue_ready is a pure function of issue_* and the counters.
    assign issue_ready = !(issue_valid && issue_wr && (issue_rd != X0_ADDR) &&
                           (pend[issue_rd] == PEND_MAX));

    assign inc_fire = !reset && issue_valid && issue_wr && issue_ready &&
                      (issue_rd != X0_ADDR);
    assign dec_fire = wb_nz && (pend[wb_addr] != '0);

    // -------------------------------------------------------------------------
    // Register storage and scoreboard counters, one slice per register.
    // Slice 0 is x0: its data register is never written and its counter is
    // tied to zero.
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        logic wr_sel;
        assign wr_sel = wb_nz && (wb_addr == REG_ADDR_WIDTH'(gi));

        always_ff @(posedge clk) begin
            if (reset) begin
                regs_q[gi] <= '0;
            end else if (wr_sel) begin
                regs_q[gi] <= wb_data;
            end
        end

        if (gi == X0_IDX) begin : g_x0
            assign pend[gi] = '0;
        end else begin : g_cnt
            logic inc_sel;
            logic dec_sel;
            assign inc_sel = inc_fire && (issue_rd == REG_ADDR_WIDTH'(gi));
            assign dec_sel = dec_fire && (wb_addr == REG_ADDR_WIDTH'(gi));

            regfile_scoreboard_pend_counter #(
                .PEND_WIDTH (PEND_WIDTH)
            ) u_pend (
                .clk     (clk),
                .reset   (reset),
                .inc_i   (inc_sel),
                .dec_i   (dec_sel),
                .count_o (pend[gi])
            );
        end
    end

    // -------------------------------------------------------------------------
    // Read ports: x0 reads zero, a same-cycle writeback is forwarded, else the
    // stored value.
    // -------------------------------------------------------------------------
    always_comb begin
        rs1_data = regs_q[rs1_addr];
        if (rs1_addr == X0_ADDR) begin
            rs1_data = '0;
        end else if (wb_fire && (wb_addr == rs1_addr)) begin
            rs1_data = wb_data;
        end
    end

    always_comb begin
        rs2_data = regs_q[rs2_addr];
        if (rs2_addr == X0_ADDR) begin
            rs2_data = '0;
        end else if (wb_fire && (wb_addr == rs2_addr)) begin
            rs2_data = wb_data;
        end
    end

    // A source whose last outstanding write is retiring this cycle is readable
    // through the bypass, so it is not reported busy. pend[0] is zero, which
    // keeps x0 never busy.
    always_comb begin
        rs1_busy = (pend[rs1_addr] != '0);
        if ((pend[rs1_addr] == PEND_ONE) && wb_fire && (wb_addr == rs1_addr)) begin
            rs1_busy = 1'b0;
        end
    end

    always_comb begin
        rs2_busy = (pend[rs2_addr] != '0);
        if ((pend[rs2_addr] == PEND_ONE) && wb_fire && (wb_addr == rs2_addr)) begin
            rs2_busy = 1'b0;
        end
    end

endmodule : regfile_scoreboard

// File: tb/tb_regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_regfile_scoreboard
//   Directed and random stimulus for regfile_scoreboard, checked every cycle
//   against an array-based reference model of the register file and the
//   per-register in-flight write counts.
// -----------------------------------------------------------------------------
module tb_regfile_scoreboard;

    logic        clk;
    logic        reset;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_en;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_wr;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        issue_ready;

    int errors = 0;
    int checks = 0;

    // Reference model: stored values and in-flight write counts (max 3).
    logic [31:0] m_regs [32];
    int          m_pend [32];

    regfile_scoreboard dut (
        .clk         (clk),
        .reset       (reset),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .wb_en       (wb_en),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_wr    (issue_wr),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .issue_ready (issue_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_data(input int a, input logic wen,
                                             input int wa, input logic [31:0] wd);
        if (a == 0) return 32'h0;
        if (wen && wa == a) return wd;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input int a, input logic wen, input int wa);
        if (a == 0) return 1'b0;
        if (m_pend[a] == 0) return 1'b0;
        if (m_pend[a] == 1 && wen && wa == a) return 1'b0;
        return 1'b1;
    endfunction

    // One clock cycle: drive inputs, check combinational outputs against the
    // model mid-cycle, then advance the model across the clock edge.
    task automatic step(input string tag, input logic rst,
                        input logic wen, input int wa, input logic [31:0] wd,
                        input int r1, input int r2,
                        input logic iv, input int ird, input logic iwr);
        logic rdy;
        reset       = rst;
        wb_en       = wen;
        wb_addr     = 5'(wa);
        wb_data     = wd;
        rs1_addr    = 5'(r1);
        rs2_addr    = 5'(r2);
        issue_valid = iv;
        issue_rd    = 5'(ird);
        issue_wr    = iwr;
        #2;
        rdy = !(iv && iwr && ird != 0 && m_pend[ird] == 3);
        check({tag, ":ready"}, {31'b0, issue_ready}, {31'b0, rdy});
        if (!rst) begin
            check({tag, ":rs1_data"}, rs1_data, exp_data(r1, wen, wa, wd));
            check({tag, ":rs2_data"}, rs2_data, exp_data(r2, wen, wa, wd));
            check({tag, ":rs1_busy"}, {31'b0, rs1_busy}, {31'b0, exp_busy(r1, wen, wa)});
            check({tag, ":rs2_busy"}, {31'b0, rs2_busy}, {31'b0, exp_busy(r2, wen, wa)});
        end
        $display("[%0t] %s rst=%0b wb=%0b r%0d<=%h rs1=r%0d:%h/%0b rs2=r%0d:%h/%0b iss=%0b r%0d rdy=%0b",
                 $time, tag, rst, wen, wa, wd, r1, rs1_data, rs1_busy,
                 r2, rs2_data, rs2_busy, iv && iwr, ird, issue_ready);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 32'h0;
                m_pend[i] = 0;
            end
        end else begin
            if (wen && wa != 0) begin
                m_regs[wa] = wd;
                if (m_pend[wa] > 0) m_pend[wa]--;
            end
            if (iv && iwr && rdy && ird != 0) m_pend[ird]++;
        end
        #1;
    endtask

    initial begin
        reset = 1'b1; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        rs1_addr = '0; rs2_addr = '0; issue_valid = 1'b0; issue_rd = '0; issue_wr = 1'b0;
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'h0;
            m_pend[i] = 0;
        end
        @(negedge clk);

        step("reset", 1, 0, 0, 32'h0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) begin
            step("post_reset_read", 0, 0, 0, 32'h0, i, 31 - i, 0, 0, 0);
        end

        // Bypass then stored read.
        step("wr5_bypass", 0, 1, 5, 32'hDEADBEEF, 5, 0, 0, 0, 0);
        step("rd5_array",  0, 0, 0, 32'h0, 5, 5, 0, 0, 0);

        // x0 writes dropped.
        step("wr_x0",   0, 1, 0, 32'h12345678, 0, 0, 0, 0, 0);
        step("rd_x0",   0, 0, 0, 32'h0, 0, 5, 0, 0, 0);

        // Single pending write retired through bypass.
        step("issue7",   0, 0, 0, 32'h0, 0, 7, 1, 7, 1);
        step("busy7",    0, 0, 0, 32'h0, 0, 7, 0, 0, 0);
        step("wb7",      0, 1, 7, 32'h55, 0, 7, 0, 0, 0);
        step("clear7",   0, 0, 0, 32'h0, 7, 7, 0, 0, 0);

        // Saturation on r3.
        step("issue3_a", 0, 0, 0, 32'h0, 3, 0, 1, 3, 1);
        step("issue3_b", 0, 0, 0, 32'h0, 3, 0, 1, 3, 1);
        step("issue3_c", 0, 0, 0, 32'h0, 3, 0, 1, 3, 1);
        step("issue3_sat", 0, 0, 0, 32'h0, 3, 0, 1, 3, 1);
        step("issue3_wb3", 0, 1, 3, 32'hA3, 3, 3, 1, 3, 1);
        step("drain3_a", 0, 1, 3, 32'hB3, 3, 0, 0, 0, 0);
        step("drain3_b", 0, 1, 3, 32'hC3, 3, 0, 0, 0, 0);
        step("idle3",    0, 0, 0, 32'h0, 3, 3, 0, 0, 0);
        step("wb3_nopend", 0, 1, 3, 32'hD3, 3, 0, 1, 3, 0);

        // Reset discards pending state and ignores a concurrent writeback.
        step("wr9",      0, 1, 9, 32'h99, 0, 0, 0, 0, 0);
        step("issue9_a", 0, 0, 0, 32'h0, 9, 0, 1, 9, 1);
        step("issue9_b", 0, 0, 0, 32'h0, 9, 0, 1, 9, 1);
        step("rst_wb9",  1, 1, 9, 32'hBAD, 9, 9, 1, 9, 1);
        step("after_rst9", 0, 0, 0, 32'h0, 9, 9, 0, 0, 0);

        // Random traffic concentrated on a few registers to reach saturation.
        for (int n = 0; n < 400; n++) begin
            logic        rr;
            logic        we;
            logic        iv;
            logic        iw;
            int          wa;
            int          ird;
            int          r1;
            int          r2;
            logic [31:0] wd;
            rr  = ($urandom_range(0, 99) == 0);
            we  = ($urandom_range(0, 2) == 0);
            wa  = $urandom_range(0, 7);
            wd  = $urandom;
            iv  = ($urandom_range(0, 1) == 1);
            iw  = ($urandom_range(0, 3) != 0);
            ird = $urandom_range(0, 7);
            r1  = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 31);
            r2  = ($urandom_range(0, 3) == 0) ? ird : $urandom_range(0, 7);
            step("rand", rr, we, wa, wd, r1, r2, iv, ird, iw);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_regfile_scoreboard
